// File: rtl/pipeline_issue_ctrl_if.sv
// Upstream instruction handshake and registered stage-1 issue fields.
// The master modport drives instructions in; the slave modport is the controller side.
interface pipeline_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ra1;
  logic [3:0] in_ra2;
  logic [3:0] in_rwa;
  logic [7:0] in_ma;
  logic [3:0] in_func;

  logic       iss_valid;
  logic [3:0] iss_ra1;
  logic [3:0] iss_ra2;
  logic [3:0] iss_rwa;
  logic [7:0] iss_ma;
  logic [3:0] iss_func;

  modport master (
    output in_valid, in_ra1, in_ra2, in_rwa, in_ma, in_func,
    input  in_ready,
    input  iss_valid, iss_ra1, iss_ra2, iss_rwa, iss_ma, iss_func
  );

  modport slave (
    input  in_valid, in_ra1, in_ra2, in_rwa, in_ma, in_func,
    output in_ready,
    output iss_valid, iss_ra1, iss_ra2, iss_rwa, iss_ma, iss_func
  );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller: FIFO-buffered instructions, RAW-hazard hold via a shifting {v,rwa} scoreboard.
// Latency: write cycle t -> iss_valid at t+2; in_ready is registered !full, so a pop frees space only next cycle.
module pipeline_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_issue_ctrl_if.slave bus,
  input  logic                 pl_en,
  input  logic                 flush,
  output logic                 illegal,
  output logic                 busy,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] rwa;
    logic [7:0] ma;
    logic [3:0] func;
  } instr_t;

  instr_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [AW:0]          count_nxt;
  logic [HAZ_DEPTH-1:0] sb_v;
  logic [3:0]           sb_rwa [HAZ_DEPTH];

  instr_t in_instr;
  instr_t head;
  logic   empty;
  logic   bad_func;
  logic   enq;
  logic   push;
  logic   pop;
  logic   hazard;
  logic   stall;

  assign in_instr = {bus.in_ra1, bus.in_ra2, bus.in_rwa, bus.in_ma, bus.in_func};
  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign bad_func = (bus.in_func > 4'b1100);
  assign enq      = bus.in_valid & bus.in_ready;
  assign push     = enq & ~bad_func & ~flush;

  // Compare only against registered slots; the instruction issuing this edge is not forwarded.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v[i] && ((sb_rwa[i] == head.ra1) || (sb_rwa[i] == head.ra2)))
        hazard = 1'b1;
    end
  end

  assign pop   = ~empty & pl_en & ~hazard & ~flush;
  assign stall = ~empty & pl_en & hazard;
  assign busy  = ~empty | (|sb_v);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      sb_v          <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++)
        sb_rwa[i]   <= '0;
      bus.in_ready  <= 1'b0;
      bus.iss_valid <= 1'b0;
      bus.iss_ra1   <= '0;
      bus.iss_ra2   <= '0;
      bus.iss_rwa   <= '0;
      bus.iss_ma    <= '0;
      bus.iss_func  <= '0;
      illegal       <= 1'b0;
      issue_cnt     <= '0;
      stall_cnt     <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      bus.in_ready <= (count_nxt != (AW+1)'(DEPTH));
      illegal      <= enq & bad_func;

      bus.iss_valid <= pop;
      if (pop) begin
        bus.iss_ra1  <= head.ra1;
        bus.iss_ra2  <= head.ra2;
        bus.iss_rwa  <= head.rwa;
        bus.iss_ma   <= head.ma;
        bus.iss_func <= head.func;
      end

      // In-flight writes still land after a flush, so the scoreboard shifts regardless.
      sb_v[0]   <= pop;
      sb_rwa[0] <= head.rwa;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_rwa[i] <= sb_rwa[i-1];
      end

      if (pop && (issue_cnt != '1))
        issue_cnt <= issue_cnt + CNT_W'(1);
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed bench for pipeline_issue_ctrl (CNT_W=4 build so saturation is reachable).
module tb_pipeline_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       pl_en;
  logic       flush;
  logic       illegal;
  logic       busy;
  logic [3:0] issue_cnt;
  logic [3:0] stall_cnt;
  int         checks = 0;
  int         errors = 0;

  pipeline_issue_ctrl_if bus ();

  pipeline_issue_ctrl #(.DEPTH(4), .HAZ_DEPTH(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pl_en     (pl_en),
    .flush     (flush),
    .illegal   (illegal),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] rwa, input logic [7:0] ma, input logic [3:0] func);
    bus.in_valid = v;
    bus.in_ra1   = ra1;
    bus.in_ra2   = ra2;
    bus.in_rwa   = rwa;
    bus.in_ma    = ma;
    bus.in_func  = func;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp = {ra1, ra2, rwa, ma, func}
  task automatic chk_iss(input string tag, input logic [23:0] exp);
    chk({tag, "_valid"}, 32'(bus.iss_valid), 32'd1);
    chk({tag, "_fields"}, 32'({bus.iss_ra1, bus.iss_ra2, bus.iss_rwa, bus.iss_ma, bus.iss_func}),
        32'(exp));
  endtask

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  initial begin
    rst   = 1'b1;
    pl_en = 1'b0;
    flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    step();
    step();
    chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // 1: three independent instructions issue on consecutive cycles
    pl_en = 1'b1;
    drive(1'b1, 4'h8, 4'h9, 4'h1, 8'h11, 4'h1); step();
    drive(1'b1, 4'h8, 4'h9, 4'h2, 8'h12, 4'h2); step();
    chk_iss("t1_i1", {4'h8, 4'h9, 4'h1, 8'h11, 4'h1});
    drive(1'b1, 4'h8, 4'h9, 4'h3, 8'h13, 4'h3); step();
    chk_iss("t1_i2", {4'h8, 4'h9, 4'h2, 8'h12, 4'h2});
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0); step();
    chk_iss("t1_i3", {4'h8, 4'h9, 4'h3, 8'h13, 4'h3});
    step();
    chk("t1_idle", 32'(bus.iss_valid), 32'd0);
    chk("t1_issue_cnt", 32'(issue_cnt), 32'd3);
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);

    // 2: dependent pair, two bubbles between issues
    drive(1'b1, 4'h8, 4'h9, 4'h5, 8'h20, 4'h2); step();
    drive(1'b1, 4'h5, 4'h9, 4'h6, 8'h21, 4'h3); step();
    chk_iss("t2_a", {4'h8, 4'h9, 4'h5, 8'h20, 4'h2});
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0); step();
    chk("t2_bubble1", 32'(bus.iss_valid), 32'd0);
    chk("t2_hold_rwa", 32'(bus.iss_rwa), 32'h5);
    step();
    chk("t2_bubble2", 32'(bus.iss_valid), 32'd0);
    step();
    chk_iss("t2_b", {4'h5, 4'h9, 4'h6, 8'h21, 4'h3});
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("t2_issue_cnt", 32'(issue_cnt), 32'd5);

    // 3: fill the FIFO with issue disabled, hold a fifth, then drain in order
    pl_en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 4'h8, 4'h9, 4'(i + 1), 8'(8'h30 + i), 4'(i));
      step();
    end
    chk("t3_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'h8, 4'h9, 4'h5, 8'h34, 4'h4);
    step();
    step();
    chk("t3_still_full", 32'(bus.in_ready), 32'd0);
    chk("t3_no_issue", 32'(bus.iss_valid), 32'd0);
    pl_en = 1'b1;
    step();
    chk_iss("t3_c0", {4'h8, 4'h9, 4'h1, 8'h30, 4'h0});
    chk("t3_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    chk_iss("t3_c1", {4'h8, 4'h9, 4'h2, 8'h31, 4'h1});
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    step();
    chk_iss("t3_c2", {4'h8, 4'h9, 4'h3, 8'h32, 4'h2});
    step();
    chk_iss("t3_c3", {4'h8, 4'h9, 4'h4, 8'h33, 4'h3});
    step();
    chk_iss("t3_c4", {4'h8, 4'h9, 4'h5, 8'h34, 4'h4});
    step();
    chk("t3_drained", 32'(bus.iss_valid), 32'd0);
    chk("t3_issue_cnt", 32'(issue_cnt), 32'd10);

    // 4: illegal opcode is dropped; 4'b1100 is still legal
    drive(1'b1, 4'h8, 4'h9, 4'h7, 8'h40, 4'hD); step();
    chk("t4_illegal", 32'(illegal), 32'd1);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0); step();
    chk("t4_illegal_pulse", 32'(illegal), 32'd0);
    chk("t4_no_issue", 32'(bus.iss_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_issue_cnt", 32'(issue_cnt), 32'd10);
    drive(1'b1, 4'h8, 4'h9, 4'h7, 8'h41, 4'hC); step();
    chk("t4_legal_edge", 32'(illegal), 32'd0);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0); step();
    chk_iss("t4_c", {4'h8, 4'h9, 4'h7, 8'h41, 4'hC});

    // 5: flush drops queue and a same-cycle push, but keeps the scoreboard
    pl_en = 1'b0;
    step();
    step();
    drive(1'b1, 4'h8, 4'h9, 4'h4, 8'h50, 4'h1); step();
    drive(1'b1, 4'h8, 4'h9, 4'h5, 8'h51, 4'h2); step();
    drive(1'b1, 4'h4, 4'h9, 4'h6, 8'h52, 4'h3); step();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    pl_en = 1'b1;
    step();
    chk_iss("t5_q0", {4'h8, 4'h9, 4'h4, 8'h50, 4'h1});
    flush = 1'b1;
    drive(1'b1, 4'h8, 4'h9, 4'h7, 8'h5F, 4'h1);
    step();
    chk("t5_flush_blocks", 32'(bus.iss_valid), 32'd0);
    chk("t5_sb_kept", 32'(busy), 32'd1);
    chk("t5_ready", 32'(bus.in_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    step();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_no_issue1", 32'(bus.iss_valid), 32'd0);
    step();
    chk("t5_no_issue2", 32'(bus.iss_valid), 32'd0);
    chk("t5_issue_cnt", 32'(issue_cnt), 32'd12);
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd2);

    // 6: dependent pairs push both counters into saturation
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 4'h8, 4'h9, 4'h1, 8'h60, 4'h1); step();
      drive(1'b1, 4'h1, 4'h9, 4'h2, 8'h61, 4'h2); step();
      drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
      step();
      step();
      step();
      step();
      chk("t6_issue_cnt", 32'(issue_cnt), sat4(12 + 2 * (p + 1)));
      chk("t6_stall_cnt", 32'(stall_cnt), sat4(2 + 2 * (p + 1)));
    end
    chk("t6_issue_sat", 32'(issue_cnt), 32'hF);
    chk("t6_stall_sat", 32'(stall_cnt), 32'hF);

    // mid-run reset overrides flush, enqueue and issue
    pl_en = 1'b0;
    drive(1'b1, 4'h8, 4'h9, 4'h3, 8'h70, 4'h2); step();
    step();
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    rst   = 1'b1;
    flush = 1'b1;
    pl_en = 1'b1;
    step();
    chk("t6_rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("t6_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("t6_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("t6_rst_iss_fields",
        32'({bus.iss_ra1, bus.iss_ra2, bus.iss_rwa, bus.iss_ma, bus.iss_func}), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst   = 1'b0;
    flush = 1'b0;
    pl_en = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
    step();
    chk("t6_ready_after_rst", 32'(bus.in_ready), 32'd1);
    chk("t6_empty_after_rst", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
